// File: rtl/riscv_lsu.sv
// Load/store unit: turns single-cycle core data accesses into handshaked, word-aligned
// bus transactions with byte enables, and stalls the core until each one completes.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic             we_q, we_d;
  logic [31:0]      wd_q, wd_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      rd_q, rd_d;
  logic             terr_q, terr_d;

  logic        legal;
  logic [3:0]  be_req;
  logic [31:0] wd_req;
  logic [31:0] lane;
  logic [31:0] ld_ext;
  logic        timeout;

  // Size/alignment legality of the incoming core access
  always_comb begin
    legal = 1'b0;
    case (core_size_i)
      3'd0:    legal = 1'b1;
      3'd1:    legal = ~core_addr_i[0];
      3'd2:    legal = (core_addr_i[1:0] == 2'b00);
      3'd4:    legal = ~core_we_i;
      3'd5:    legal = ~core_we_i & ~core_addr_i[0];
      default: legal = 1'b0;
    endcase
  end

  // Byte enables and lane-replicated store data; BU/HU share B/H encodings in size[1:0]
  always_comb begin
    be_req = 4'b1111;
    wd_req = core_wd_i;
    case (core_size_i[1:0])
      2'd0: begin
        be_req = 4'b0001 << core_addr_i[1:0];
        wd_req = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        be_req = 4'b0011 << core_addr_i[1:0];
        wd_req = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_req = 4'b1111;
        wd_req = core_wd_i;
      end
    endcase
  end

  // Lane extraction and sign/zero extension of the returned word
  always_comb begin
    lane = mem_rdata_i >> {addr_q[1:0], 3'b000};
    case (size_q)
      3'd0:    ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    ld_ext = {24'd0, lane[7:0]};
      3'd5:    ld_ext = {16'd0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  assign timeout = (cnt_q == CNT_LAST);

  // Next-state logic; a response arriving on the last allowed cycle still completes normally
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wd_d    = wd_q;
    be_d    = be_q;
    rd_d    = rd_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (core_req_i && legal) begin
          addr_d  = core_addr_i;
          size_d  = core_size_i;
          we_d    = core_we_i;
          wd_d    = wd_req;
          be_d    = be_req;
          terr_d  = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          rd_d    = '0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else if (mem_gnt_i) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid_i) begin
          rd_d    = ld_ext;
          terr_d  = 1'b0;
          state_d = S_DONE;
        end else if (timeout) begin
          rd_d    = '0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        terr_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      be_q    <= '0;
      rd_q    <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
      terr_q  <= terr_d;
    end
  end

  // Stall/err must react in the request cycle itself, so they are decoded from state and inputs
  assign core_stall_o = ~reset & ((state_q == S_IDLE & core_req_i & legal) |
                                  (state_q == S_REQ) | (state_q == S_RESP));
  assign core_err_o   = ~reset & ((state_q == S_IDLE & core_req_i & ~legal) |
                                  (state_q == S_DONE & terr_q));
  assign core_rd_o    = rd_q;
  assign mem_req_o    = ~reset & (state_q == S_REQ);
  assign mem_we_o     = we_q;
  assign mem_be_o     = be_q;
  assign mem_addr_o   = {addr_q[31:2], 2'b00};
  assign mem_wd_o     = wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed and randomized accesses against an
// arithmetic reference model of byte enables, lane replication and load extension.
module tb_riscv_lsu;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wd;
  logic [31:0] core_rd;
  logic        core_stall, core_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;

  riscv_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd), .core_stall_o(core_stall), .core_err_o(core_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic int m_nbytes(input logic [2:0] size);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit we, input logic [2:0] size, input logic [31:0] addr);
    int n = m_nbytes(size);
    int off = int'(addr[1:0]);
    if (n == 0) return 1'b0;
    if (we && size >= 3'd4) return 1'b0;
    return (off % n) == 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
    logic [3:0] be;
    int n = m_nbytes(size);
    int off = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] w;
    int n = m_nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] size, input logic [31:0] addr,
                                       input logic [31:0] rdata);
    longint v;
    longint lim;
    int n = m_nbytes(size);
    v = longint'({32'd0, rdata});
    v = v >> (8 * int'(addr[1:0]));
    if (n < 4) begin
      lim = longint'(1) << (8 * n);
      v = v % lim;
      if (size < 3'd4 && v >= lim / 2) v = v - lim;
    end
    return v[31:0];
  endfunction

  // Drive one core access; gnt_dly/rv_dly < 0 means the bus never answers that phase
  task automatic run_access(input string name, input bit we, input logic [2:0] size,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
    bit lg, granted, done;
    int k;
    lg = m_legal(we, size, addr);
    core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    if (!lg) begin
      total++; if (core_err !== 1'b1) begin bad++; $display("FAIL %s ill_err got=%b want=1", name, core_err); end
      total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL %s ill_stall got=%b want=0", name, core_stall); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s ill_req got=%b want=0", name, mem_req); end
      @(posedge clk); #1 core_req = 1'b0;
      @(negedge clk);
      total++; if (core_err !== 1'b0) begin bad++; $display("FAIL %s ill_err_pulse got=%b want=0", name, core_err); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s ill_req_after got=%b want=0", name, mem_req); end
      @(posedge clk); #1;
      return;
    end
    total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL %s idle_stall got=%b want=1", name, core_stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s idle_req got=%b want=0", name, mem_req); end
    granted = 1'b0; done = 1'b0; k = 0;
    for (int c = 0; c < TMO && !done; c++) begin
      @(posedge clk); #1;
      if (!granted) begin
        mem_gnt = (k == gnt_dly);
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end else begin
        mem_gnt = 1'b0;
        mem_rvalid = (rv_dly >= 0) && (k == rv_dly);
        mem_rdata = mem_rvalid ? rdata : $urandom;
      end
      @(negedge clk);
      total++; if (core_stall !== 1'b1) begin bad++; $display("FAIL %s bus_stall c=%0d got=%b want=1", name, c, core_stall); end
      if (!granted) begin
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL %s req_held c=%0d got=%b want=1", name, c, mem_req); end
        total++; if (mem_addr !== {addr[31:2], 2'b00}) begin bad++; $display("FAIL %s addr got=%h want=%h", name, mem_addr, {addr[31:2], 2'b00}); end
        total++; if (mem_be !== m_be(size, addr)) begin bad++; $display("FAIL %s be got=%b want=%b", name, mem_be, m_be(size, addr)); end
        total++; if (mem_we !== we) begin bad++; $display("FAIL %s we got=%b want=%b", name, mem_we, we); end
        if (we) begin
          total++; if (mem_wd !== m_wd(size, wd)) begin bad++; $display("FAIL %s wd got=%h want=%h", name, mem_wd, m_wd(size, wd)); end
        end
        if (mem_gnt) begin granted = 1'b1; k = 0; end else k++;
      end else begin
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s resp_req c=%0d got=%b want=0", name, c, mem_req); end
        if (mem_rvalid) done = 1'b1; else k++;
      end
    end
    @(posedge clk); #1 mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL %s done_stall got=%b want=0", name, core_stall); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL %s done_req got=%b want=0", name, mem_req); end
    total++; if (core_err !== !done) begin bad++; $display("FAIL %s done_err got=%b want=%b", name, core_err, !done); end
    if (!we || !done) begin
      total++; if (core_rd !== (done ? m_rd(size, addr, rdata) : 32'd0)) begin
        bad++; $display("FAIL %s rd got=%h want=%h", name, core_rd, done ? m_rd(size, addr, rdata) : 32'd0); end
    end
    @(posedge clk); #1 core_req = 1'b0;
    @(negedge clk);
    total++; if (core_err !== 1'b0) begin bad++; $display("FAIL %s idle_err got=%b want=0", name, core_err); end
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL %s idle_after_stall got=%b want=0", name, core_stall); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; core_req = 1'b1; core_we = 1'b0; core_size = 3'd2;
    core_addr = 32'h100; core_wd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (core_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", core_stall); end
    total++; if (core_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", core_err); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", mem_req); end
    total++; if ({mem_we, mem_be, mem_addr, mem_wd, core_rd} !== '0) begin
      bad++; $display("FAIL reset_outs got we=%b be=%b addr=%h wd=%h rd=%h want all 0", mem_we, mem_be, mem_addr, mem_wd, core_rd); end
    @(posedge clk); #1 reset = 1'b0; core_req = 1'b0;
  endtask

  task automatic test_directed();
    run_access("lw",  1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    run_access("lb",  1'b0, 3'd0, 32'h103, 32'h0, 32'h80112233, 0, 0);
    run_access("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80112233, 0, 0);
    run_access("sh",  1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0, 5, 0);
    run_access("lw_mis", 1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 0);
    run_access("sb_sz4", 1'b1, 3'd4, 32'h100, 32'h12, 32'h0, 0, 0);
    run_access("lh_mis", 1'b0, 3'd1, 32'h103, 32'h0, 32'h0, 0, 0);
    run_access("sz3", 1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 0);
  endtask

  task automatic test_timeout();
    run_access("to_resp", 1'b0, 3'd2, 32'h200, 32'h0, 32'h0, 0, -1);
    run_access("to_req",  1'b1, 3'd2, 32'h204, 32'h55AA55AA, 32'h0, -1, -1);
    run_access("after_to", 1'b0, 3'd5, 32'h202, 32'h0, 32'h9ABC1234, 1, 2);
  endtask

  task automatic test_stale_rvalid();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0) begin
      bad++; $display("FAIL stale_idle got req=%b stall=%b err=%b want 0 0 0", mem_req, core_stall, core_err); end
    @(posedge clk); #1 mem_rvalid = 1'b0;
    run_access("post_stale", 1'b0, 3'd0, 32'h301, 32'h0, 32'h0000F700, 2, 1);
  endtask

  task automatic test_reset_mid();
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h400;
    mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0) begin
      bad++; $display("FAIL midrst_during got req=%b stall=%b err=%b want 0 0 0", mem_req, core_stall, core_err); end
    @(posedge clk); #1 reset = 1'b0; core_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    @(negedge clk);
    total++; if (mem_req !== 1'b0 || core_stall !== 1'b0 || core_err !== 1'b0 || core_rd !== 32'd0) begin
      bad++; $display("FAIL midrst_after got req=%b stall=%b err=%b rd=%h want 0 0 0 0", mem_req, core_stall, core_err, core_rd); end
    @(posedge clk); #1 mem_rvalid = 1'b0;
    @(negedge clk);
    total++; if (core_rd !== 32'd0 || core_err !== 1'b0) begin
      bad++; $display("FAIL midrst_ignored got rd=%h err=%b want 0 0", core_rd, core_err); end
    @(posedge clk); #1;
    run_access("midrst_lw", 1'b0, 3'd2, 32'h400, 32'h0, 32'h0BADCAFE, 0, 0);
  endtask

  task automatic test_random();
    logic [2:0] sizes [8];
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 40; i++) begin
      run_access("rand", 1'($urandom_range(0, 1)), sizes[$urandom_range(0, 7)],
                 $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      run_access("b2b", 1'b0, 3'd1, 32'h500 + 32'(2 * i), 32'h0, 32'h8001_7FFE, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_stale_rvalid();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
